// File: rtl/alu32_if.sv
// Operand/opcode/result bundle for the execute-stage ALU.
// The master drives operands and opcode; the ALU, as slave, returns the registered result and zero flag.
interface alu32_if;
  logic [31:0] OP1;
  logic [31:0] OP2;
  logic [3:0]  OPRN;
  logic [31:0] OUT;
  logic        ZERO;

  modport master (output OP1, output OP2, output OPRN, input OUT, input ZERO);
  modport slave  (input OP1, input OP2, input OPRN, output OUT, output ZERO);
endinterface

// File: rtl/alu32.sv
// 32-bit execute-stage ALU: add/sub/mul/shifts/logic/slt with a registered result and zero flag.
// Outputs have one cycle of latency, and reset is synchronous and active-high.
module alu32 (
  input  logic    CLK,
  input  logic    RST,
  alu32_if.slave  bus
);

  typedef enum logic [3:0] {
    OP_ADD = 4'b0001,
    OP_SUB = 4'b0010,
    OP_MUL = 4'b0011,
    OP_SRL = 4'b0100,
    OP_SLL = 4'b0101,
    OP_AND = 4'b0110,
    OP_OR  = 4'b0111,
    OP_NOR = 4'b1000,
    OP_SLT = 4'b1001
  } opcode_e;

  logic        sub_sel;
  logic [31:0] addb;
  logic [31:0] addres;
  logic [31:0] prod;
  logic        ovf;
  logic        lt;
  logic        shift_kill;
  logic [31:0] srl_res;
  logic [31:0] sll_res;
  logic [31:0] res;

  // sub and slt share the adder, which computes OP1 + ~OP2 + 1
  always_comb begin
    sub_sel = (bus.OPRN == OP_SUB) || (bus.OPRN == OP_SLT);
    addb    = sub_sel ? ~bus.OP2 : bus.OP2;
    addres  = bus.OP1 + addb + {31'b0, sub_sel};
    prod    = bus.OP1 * bus.OP2;
    ovf     = (bus.OP1[31] != bus.OP2[31]) && (addres[31] != bus.OP1[31]);
    lt      = addres[31] ^ ovf;
  end

  // Five-stage barrel shifters; any set bit in OP2[31:5] forces the result to zero
  always_comb begin
    shift_kill = |bus.OP2[31:5];
    srl_res    = bus.OP1;
    sll_res    = bus.OP1;
    for (int unsigned i = 0; i < 5; i++) begin
      if (bus.OP2[i]) begin
        srl_res = srl_res >> (1 << i);
        sll_res = sll_res << (1 << i);
      end
    end
    if (shift_kill) begin
      srl_res = '0;
      sll_res = '0;
    end
  end

  always_comb begin
    res = '0;
    case (bus.OPRN)
      OP_ADD:  res = addres;
      OP_SUB:  res = addres;
      OP_MUL:  res = prod;
      OP_SRL:  res = srl_res;
      OP_SLL:  res = sll_res;
      OP_AND:  res = bus.OP1 & bus.OP2;
      OP_OR:   res = bus.OP1 | bus.OP2;
      OP_NOR:  res = ~(bus.OP1 | bus.OP2);
      OP_SLT:  res = {31'b0, lt};
      default: res = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      bus.OUT  <= '0;
      bus.ZERO <= 1'b1;
    end else begin
      bus.OUT  <= res;
      bus.ZERO <= (res == '0);
    end
  end

endmodule

// File: tb/tb_alu32.sv
// Directed-vector bench for alu32.
// Each vector drives operands, then checks that OUT holds its old value before the edge and the new result after it.
module tb_alu32;

  logic CLK;
  logic RST;
  int   n_checks;
  int   n_errors;
  logic [31:0] prev;

  alu32_if bus ();

  alu32 dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one vector shortly after a rising edge, confirm OUT is still the
  // previous result, then check the new result one edge later.
  task automatic step(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] opr, input logic [31:0] exp);
    bus.OP1  = a;
    bus.OP2  = b;
    bus.OPRN = opr;
    #1;
    check({tag, "_hold"}, bus.OUT, prev);
    @(posedge CLK);
    #1;
    check(tag, bus.OUT, exp);
    check({tag, "_zero"}, {31'b0, bus.ZERO}, {31'b0, exp == 32'd0});
    prev = exp;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    RST      = 1'b1;
    bus.OP1  = 32'hDEAD_BEEF;
    bus.OP2  = 32'h1234_5678;
    bus.OPRN = 4'b0011;
    @(posedge CLK);
    #1;
    @(posedge CLK);
    #1;
    check("reset_out", bus.OUT, 32'd0);
    check("reset_zero", {31'b0, bus.ZERO}, 32'd1);
    prev = 32'd0;

    RST = 1'b0;
    step("add_9_8",      32'd9,          32'd8,          4'b0001, 32'd17);
    step("sub_9_8",      32'd9,          32'd8,          4'b0010, 32'd1);
    step("mul_9_8",      32'd9,          32'd8,          4'b0011, 32'd72);
    step("add_wrap",     32'hFFFF_FFFF,  32'd1,          4'b0001, 32'd0);
    step("sub_wrap",     32'd0,          32'd1,          4'b0010, 32'hFFFF_FFFF);
    step("mul_wrap",     32'h0001_0000,  32'h0001_0000,  4'b0011, 32'd0);

    step("srl_8",        32'd9,          32'd8,          4'b0100, 32'd0);
    step("srl_1",        32'd9,          32'd1,          4'b0100, 32'd4);
    step("sll_8",        32'd9,          32'd8,          4'b0101, 32'h0000_0900);
    step("sll_1",        32'd9,          32'd1,          4'b0101, 32'd18);
    step("sll_32",       32'd9,          32'd32,         4'b0101, 32'd0);
    step("srl_0",        32'd9,          32'd0,          4'b0100, 32'd9);
    step("srl_hi_amt",   32'h8000_0000,  32'h8000_0001,  4'b0100, 32'd0);
    step("sll_31",       32'd1,          32'd31,         4'b0101, 32'h8000_0000);
    step("srl_31",       32'h8000_0000,  32'd31,         4'b0100, 32'd1);

    step("and_9_8",      32'd9,          32'd8,          4'b0110, 32'd8);
    step("or_9_8",       32'd9,          32'd8,          4'b0111, 32'd9);
    step("nor_9_8",      32'd9,          32'd8,          4'b1000, 32'hFFFF_FFF6);

    step("slt_9_8",      32'd9,          32'd8,          4'b1001, 32'd0);
    step("slt_8_9",      32'd8,          32'd9,          4'b1001, 32'd1);
    step("slt_m1_1",     32'hFFFF_FFFF,  32'd1,          4'b1001, 32'd1);
    step("slt_max_min",  32'h7FFF_FFFF,  32'h8000_0000,  4'b1001, 32'd0);
    step("slt_min_max",  32'h8000_0000,  32'h7FFF_FFFF,  4'b1001, 32'd1);
    step("slt_equal",    32'd5,          32'd5,          4'b1001, 32'd0);

    step("pipe_add",     32'd9,          32'd8,          4'b0001, 32'd17);
    step("pipe_sub",     32'd9,          32'd8,          4'b0010, 32'd1);
    step("pipe_mul",     32'd9,          32'd8,          4'b0011, 32'd72);
    step("pipe_and",     32'd9,          32'd8,          4'b0110, 32'd8);

    step("op_1111",      32'd9,          32'd8,          4'b1111, 32'd0);
    step("op_0000",      32'd9,          32'd8,          4'b0000, 32'd0);
    step("op_1010",      32'hFFFF_FFFF,  32'hFFFF_FFFF,  4'b1010, 32'd0);
    step("add_again",    32'd100,        32'd23,         4'b0001, 32'd123);

    RST      = 1'b1;
    bus.OP1  = 32'd9;
    bus.OP2  = 32'd8;
    bus.OPRN = 4'b0001;
    @(posedge CLK);
    #1;
    check("midrst_out", bus.OUT, 32'd0);
    check("midrst_zero", {31'b0, bus.ZERO}, 32'd1);
    RST  = 1'b0;
    prev = 32'd0;
    step("post_rst_add", 32'd9,          32'd8,          4'b0001, 32'd17);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
